engine_prog_nfa: RTL and testbench
==================================

// Module: engine_prog_nfa
// PURPOSE
//  Runtime-programmable bit-parallel (Shift-And) NFA payload matcher. It is the parametrised successor of
//  the per-rule hardwired engine_* blocks.
//  Matches a chain of up to MAX_LEN single-byte classes: literal or negated, case-folded or exact, each
//  optionally self-looping (x+). Sits in payload_engine beside the fixed engines.
//  Adds a sticky match flag, a match pulse, a saturating match count and the byte offset of the first match.
// PARAMETERS
//  MAX_LEN  16  max pattern positions (2..64); AW = $clog2(MAX_LEN)
//  CNT_W    16  match counter width
//  OFF_W    16  byte-offset counter width
// PORTS
//  clk            in   1      clock; all logic rising-edge
//  rst            in   1      reset, asynchronous, active-high; clears state, outputs AND config
//  sod            in   1      start of data; synchronous per-packet clear (config kept)
//  en             in   1      in_byte valid this cycle
//  in_byte        in   8      payload byte
//  cfg_we         in   1      write position cfg_addr
//  cfg_addr       in   AW     position index
//  cfg_char       in   8      class byte
//  cfg_nocase     in   1      ASCII case-fold compare (A-Z == a-z)
//  cfg_neg        in   1      class = any byte except cfg_char (under the same fold rule)
//  cfg_loop       in   1      position may repeat (self-loop)
//  cfg_len_we     in   1      write pattern length
//  cfg_len        in   AW+1   active length 0..MAX_LEN; 0 = engine disabled
//  cfg_anchor     in   1      (latched with cfg_len_we) position 0 only armed on first byte after sod
//  out            out  1      sticky match since last sod
//  match_pulse    out  1      1-cycle pulse per cycle the final position is reached
//  match_cnt      out  CNT_W  saturating count of match_pulse since sod
//  match_off      out  OFF_W  offset (0-based) of the last byte of the first match; valid when out=1
// BEHAVIOUR
//  - rst: all position configs = 0, len = 0, anchor = 0, S = 0, every output 0, offset counter 0.
//  - Config registers are written on the clock edge. A write applies to bytes presented from the next cycle.
//    Writes with en=1 are legal. cfg_addr >= MAX_LEN is ignored. cfg_len > MAX_LEN is clamped to MAX_LEN.
//  - hit[i] = (fold(in_byte) == fold(char[i])) XOR neg[i]. fold() maps A-Z to a-z only when nocase[i]=1.
//  - On en: S'[i] = hit[i] & (arm[i] | (loop[i] & S[i])).
//    arm[0] = ~anchor | first; arm[i>0] = S[i-1].
//    first = 1 for the first en byte after sod/rst. Positions >= len are forced 0.
//  - No en: S, counters and outputs hold. match_pulse = 0.
//  - Latency: match_pulse = 1 in the cycle after the en byte that sets S'[len-1]. out, cnt and off update
//    on the same edge.
//  - Offset counter: 0 for the first byte after sod. Increments per en byte and saturates at all-ones.
//    match_off is captured only on the first match (out 0->1) and holds afterwards.
//  - match_cnt saturates at all-ones and never wraps. out holds 1 until sod/rst.
//  - sod with en=0: S, out, match_pulse, cnt, off and offset counter are cleared. first is re-armed.
//  - sod with en=1: clear as above, then in_byte is processed as byte offset 0 with first=1.
//    Prior-packet state never contributes.
//  - cfg_len = 0 or len written mid-stream: positions >= new len are cleared the next cycle. No spurious pulse.
//  - rst asserted mid-stream: immediate async clear. After release the engine is disabled until reprogrammed.
// TESTING
//  1) Program "?open=" (len 6, exact), stream "xx?open=" -> match_pulse 1 cycle after '=', match_off=7,
//     match_cnt=1, out stays 1.
//  2) nocase on all positions, pattern "myid", stream "MyId..myID" -> match_cnt=2, match_off=3.
//  3) Pattern "[^&]+&m" (pos0 neg '&' loop, pos1 '&', pos2 'm'), stream "ab&m" -> match at offset 3;
//     stream "&m" -> no match.
//  4) cfg_anchor=1, pattern "ab": "abab" -> cnt=1, off=1; "xab" -> no match.
//     sod+en with 'a' then 'b' -> match with off=1.
//  5) len=2 "aa": 2^CNT_W+3 bytes of 'a' -> match_cnt saturates at all-ones.
//     Offset counter saturates. No wrap.
//  6) rst pulse mid-match (S[0]=1) -> out/cnt/off/match_pulse 0 immediately.
//     len=0: stream "?open=" -> no match until reprogrammed.

Source files
------------

// File: rtl/engine_prog_nfa_if.sv
// Byte stream, configuration and match-report signals of the programmable NFA matcher.
// The engine connects through the slave modport, its driver through the master modport.
interface engine_prog_nfa_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16,
  parameter int OFF_W   = 16
);
  localparam int AW = $clog2(MAX_LEN);

  logic             sod;
  logic             en;
  logic [7:0]       in_byte;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [7:0]       cfg_char;
  logic             cfg_nocase;
  logic             cfg_neg;
  logic             cfg_loop;
  logic             cfg_len_we;
  logic [AW:0]      cfg_len;
  logic             cfg_anchor;
  logic             out;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;
  logic [OFF_W-1:0] match_off;

  modport master (
    output sod, en, in_byte,
    output cfg_we, cfg_addr, cfg_char, cfg_nocase, cfg_neg, cfg_loop,
    output cfg_len_we, cfg_len, cfg_anchor,
    input  out, match_pulse, match_cnt, match_off
  );

  modport slave (
    input  sod, en, in_byte,
    input  cfg_we, cfg_addr, cfg_char, cfg_nocase, cfg_neg, cfg_loop,
    input  cfg_len_we, cfg_len, cfg_anchor,
    output out, match_pulse, match_cnt, match_off
  );
endinterface

// File: rtl/engine_prog_nfa.sv
// Runtime-programmable Shift-And NFA payload matcher: a chain of byte classes (literal/negated,
// exact/case-folded, optional self-loop) with sticky flag, pulse, saturating count and first-match offset.
module engine_prog_nfa #(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 16,
  parameter  int OFF_W   = 16,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  engine_prog_nfa_if.slave bus
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

  // Per-position class configuration
  logic [7:0]         char_q [MAX_LEN];
  logic [MAX_LEN-1:0] nocase_q;
  logic [MAX_LEN-1:0] neg_q;
  logic [MAX_LEN-1:0] loop_q;
  logic [AW:0]        len_q,    len_d;
  logic               anchor_q, anchor_d;

  // Matching state and report registers
  logic [MAX_LEN-1:0] s_q,      s_d;
  logic               first_q,  first_d;
  logic               out_q,    out_d;
  logic               pulse_q,  pulse_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [OFF_W-1:0]   moff_q,   moff_d;
  logic [OFF_W-1:0]   ofs_q,    ofs_d;

  logic [MAX_LEN-1:0] hit;
  logic [MAX_LEN-1:0] arm;
  logic [MAX_LEN-1:0] s_base;
  logic [MAX_LEN-1:0] s_step;
  logic [MAX_LEN-1:0] act_mask;
  logic [MAX_LEN-1:0] final_mask;
  logic               final_hit;
  logic               first_base;
  logic               out_base;
  logic [CNT_W-1:0]   cnt_base;
  logic [OFF_W-1:0]   moff_base;
  logic [OFF_W-1:0]   ofs_base;
  logic [AW:0]        len_wr;
  logic               addr_ok;

  function automatic logic [7:0] fold(input logic [7:0] c, input logic nc);
    fold = (nc && c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

  // Bits [0 .. l-1] set: the positions that belong to an active pattern of length l.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [AW:0] l);
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(l));
  endfunction

  assign len_wr  = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
  assign addr_ok = int'(bus.cfg_addr) < MAX_LEN;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    hit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      hit[i] = (fold(bus.in_byte, nocase_q[i]) == fold(char_q[i], nocase_q[i])) ^ neg_q[i];
    end
  end

  // sod clears the packet state first, so a byte arriving with sod sees a fresh engine at offset 0.
  always_comb begin
    s_base     = bus.sod ? '0 : s_q;
    first_base = bus.sod | first_q;
    out_base   = bus.sod ? 1'b0 : out_q;
    cnt_base   = bus.sod ? '0 : cnt_q;
    moff_base  = bus.sod ? '0 : moff_q;
    ofs_base   = bus.sod ? '0 : ofs_q;

    act_mask   = len_mask(len_q);
    final_mask = act_mask & ~(act_mask >> 1);
    arm        = {s_base[MAX_LEN-2:0], ~anchor_q | first_base};
    s_step     = hit & (arm | (loop_q & s_base)) & act_mask;
    final_hit  = |(s_step & final_mask);

    s_d      = s_base;
    first_d  = first_base;
    out_d    = out_base;
    cnt_d    = cnt_base;
    moff_d   = moff_base;
    ofs_d    = ofs_base;
    pulse_d  = 1'b0;

    if (bus.en) begin
      s_d     = s_step;
      first_d = 1'b0;
      pulse_d = final_hit;
      if (final_hit) begin
        if (cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
        if (!out_base) begin
          out_d  = 1'b1;
          moff_d = ofs_base;
        end
      end
      if (ofs_base != '1) ofs_d = ofs_base + OFF_W'(1);
    end

    len_d    = bus.cfg_len_we ? len_wr : len_q;
    anchor_d = bus.cfg_len_we ? bus.cfg_anchor : anchor_q;
    // Positions beyond a shrunk length drop out so they can never re-arm a later position.
    s_d      = s_d & len_mask(len_d);
  end

  // NOTE: the configuration array is cleared on rst as well, so the engine comes up disabled and deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) char_q[i] <= '0;
      nocase_q <= '0;
      neg_q    <= '0;
      loop_q   <= '0;
    end else if (bus.cfg_we && addr_ok) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      char_q[bus.cfg_addr]   <= bus.cfg_char;
      nocase_q[bus.cfg_addr] <= bus.cfg_nocase;
      neg_q[bus.cfg_addr]    <= bus.cfg_neg;
      loop_q[bus.cfg_addr]   <= bus.cfg_loop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      anchor_q <= 1'b0;
      s_q      <= '0;
      first_q  <= 1'b1;
      out_q    <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
      moff_q   <= '0;
      ofs_q    <= '0;
    end else begin
      len_q    <= len_d;
      anchor_q <= anchor_d;
      s_q      <= s_d;
      first_q  <= first_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
      moff_q   <= moff_d;
      ofs_q    <= ofs_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_cnt   = cnt_q;
  assign bus.match_off   = moff_q;

endmodule

// File: tb/tb_engine_prog_nfa.sv
// Self-checking bench for engine_prog_nfa: directed scenarios plus randomized packets, all checked
// against a regex-level model that searches the packet history for a match ending at each byte.
module tb_engine_prog_nfa;

  localparam int ML       = 12;
  localparam int CW       = 4;
  localparam int OW       = 5;
  localparam int AW       = $clog2(ML);
  localparam int CNT_MAX  = (1 << CW) - 1;
  localparam int OFF_MAX  = (1 << OW) - 1;
  localparam int HIST_MAX = 64;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  engine_prog_nfa_if #(.MAX_LEN(ML), .CNT_W(CW), .OFF_W(OW)) bus ();

  engine_prog_nfa #(.MAX_LEN(ML), .CNT_W(CW), .OFF_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: configuration, packet history and report state
  logic [7:0] mchar [16];
  bit         mnc   [16];
  bit         mneg  [16];
  bit         mloop [16];
  int         mlen;
  bit         manchor;
  logic [7:0] hist [$];
  int         mcnt;
  bit         mout;
  int         moff;

  logic [7:0] alpha [6] = '{8'h61, 8'h41, 8'h62, 8'h42, 8'h26, 8'h78};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int i, input logic [7:0] b);
    logic [7:0] x, y;
    x = b;
    y = mchar[i];
    if (mnc[i] && x >= 8'd65 && x <= 8'd90) x = x + 8'd32;
    if (mnc[i] && y >= 8'd65 && y <= 8'd90) y = y + 8'd32;
    return (x == y) ^ mneg[i];
  endfunction

  // Does some substring of the packet ending at its last byte match the class chain (x+ for loops)?
  // ok[i][k]: positions i..len-1 consume exactly bytes k..last.
  function automatic bit model_match();
    bit ok [ML+1][HIST_MAX+1];
    int j, res;
    j = hist.size() - 1;
    if (mlen == 0) return 1'b0;
    for (int k = j + 1; k >= 0; k--) begin
      for (int i = mlen; i >= 0; i--) begin
        if (i == mlen)       ok[i][k] = (k == j + 1);
        else if (k == j + 1) ok[i][k] = 1'b0;
        else ok[i][k] = m_hit(i, hist[k]) && (ok[i+1][k+1] || (mloop[i] && ok[i][k+1]));
      end
    end
    res = 0;
    if (manchor) res = ok[0][0];
    else for (int k = 0; k <= j; k++) if (ok[0][k]) res = 1;
    return res != 0;
  endfunction

  task automatic model_clear();
    hist.delete();
    mcnt = 0;
    mout = 0;
    moff = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input bit exp_pulse);
    check("match_pulse", bus.match_pulse, exp_pulse);
    check("out",         bus.out,         mout);
    check("match_cnt",   bus.match_cnt,   mcnt);
    check("match_off",   bus.match_off,   moff);
  endtask

  task automatic send(input logic [7:0] b, input bit with_sod = 1'b0);
    bit m;
    int j;
    bus.en = 1'b1; bus.in_byte = b; bus.sod = with_sod;
    if (with_sod) model_clear();
    hist.push_back(b);
    j = hist.size() - 1;
    m = model_match();
    if (m) begin
      if (mcnt < CNT_MAX) mcnt++;
      if (!mout) begin
        mout = 1;
        moff = (j < OFF_MAX) ? j : OFF_MAX;
      end
    end
    cyc();
    bus.en = 1'b0; bus.sod = 1'b0;
    check_outputs(m);
  endtask

  task automatic send_str(input string s, input bit first_sod = 1'b0);
    for (int i = 0; i < s.len(); i++) send(s[i], first_sod && i == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_outputs(1'b0);
    end
  endtask

  task automatic sod_only();
    bus.sod = 1'b1;
    model_clear();
    cyc();
    bus.sod = 1'b0;
    check_outputs(1'b0);
  endtask

  task automatic write_pos(input int addr, input logic [7:0] ch, input bit nc, input bit ng, input bit lp);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(addr); bus.cfg_char = ch;
    bus.cfg_nocase = nc; bus.cfg_neg = ng; bus.cfg_loop = lp;
    cyc();
    bus.cfg_we = 1'b0;
    if (addr < ML) begin
      mchar[addr] = ch; mnc[addr] = nc; mneg[addr] = ng; mloop[addr] = lp;
    end
  endtask

  task automatic write_len(input int l, input bit anc);
    bus.cfg_len_we = 1'b1; bus.cfg_len = (AW+1)'(l); bus.cfg_anchor = anc;
    cyc();
    bus.cfg_len_we = 1'b0;
    mlen    = (l > ML) ? ML : l;
    manchor = anc;
  endtask

  task automatic program_str(input string s, input bit nc);
    for (int i = 0; i < s.len(); i++) write_pos(i, s[i], nc, 1'b0, 1'b0);
    write_len(s.len(), 1'b0);
  endtask

  initial begin
    bus.sod = 0; bus.en = 0; bus.in_byte = 0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_char = 0;
    bus.cfg_nocase = 0; bus.cfg_neg = 0; bus.cfg_loop = 0;
    bus.cfg_len_we = 0; bus.cfg_len = 0; bus.cfg_anchor = 0;
    for (int i = 0; i < 16; i++) begin
      mchar[i] = 0; mnc[i] = 0; mneg[i] = 0; mloop[i] = 0;
    end
    mlen = 0; manchor = 0;
    model_clear();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0);
    rst = 1'b0;
    cyc();

    // Literal pattern, exact case
    program_str("?open=", 1'b0);
    send_str("xx?open=", 1'b1);
    check("t1_off", bus.match_off, 7);
    check("t1_cnt", bus.match_cnt, 1);
    send("z");
    check("t1_sticky", bus.out, 1);
    idle(2);

    // Case-folded pattern, two matches
    program_str("myid", 1'b1);
    send_str("MyId..myID", 1'b1);
    check("t2_cnt", bus.match_cnt, 2);
    check("t2_off", bus.match_off, 3);

    // Negated looping class followed by literals
    write_pos(0, "&", 1'b0, 1'b1, 1'b1);
    write_pos(1, "&", 1'b0, 1'b0, 1'b0);
    write_pos(2, "m", 1'b0, 1'b0, 1'b0);
    write_len(3, 1'b0);
    send_str("ab&m", 1'b1);
    check("t3_out", bus.out, 1);
    check("t3_off", bus.match_off, 3);
    send_str("&m", 1'b1);
    check("t3_nomatch", bus.out, 0);

    // Anchored pattern
    write_pos(0, "a", 1'b0, 1'b0, 1'b0);
    write_pos(1, "b", 1'b0, 1'b0, 1'b0);
    write_len(2, 1'b1);
    sod_only();
    send_str("abab");
    check("t4_cnt", bus.match_cnt, 1);
    check("t4_off", bus.match_off, 1);
    sod_only();
    send_str("xab");
    check("t4_unanchored", bus.out, 0);
    send_str("ab", 1'b1);
    check("t4_sod_en", bus.out, 1);
    check("t4_sod_off", bus.match_off, 1);

    // Count and offset saturation
    write_pos(0, "a", 1'b0, 1'b0, 1'b0);
    write_pos(1, "a", 1'b0, 1'b0, 1'b0);
    write_len(2, 1'b0);
    sod_only();
    for (int i = 0; i < (1 << CW) + 3; i++) send("a");
    check("t5_cnt_sat", bus.match_cnt, CNT_MAX);
    write_pos(1, "b", 1'b0, 1'b0, 1'b0);
    sod_only();
    for (int i = 0; i < OFF_MAX + 8; i++) send("x");
    send_str("ab");
    check("t5_off_sat", bus.match_off, OFF_MAX);

    // Length clamp and out-of-range address
    program_str("abcdefghijkl", 1'b0);
    write_pos(13, "z", 1'b0, 1'b0, 1'b0);
    write_len(20, 1'b0);
    send_str("abcdefghijkl", 1'b1);
    check("clamp_out", bus.out, 1);

    // Length changes around a partial match (model bypassed, sod resynchronises)
    write_pos(0, "a", 1'b0, 1'b0, 1'b0);
    write_pos(1, "b", 1'b0, 1'b0, 1'b0);
    write_len(2, 1'b0);
    sod_only();
    bus.en = 1; bus.in_byte = "a"; cyc();
    bus.in_byte = "b"; bus.cfg_len_we = 1; bus.cfg_len = 0; cyc();
    bus.en = 0; bus.cfg_len_we = 0;
    check("len_wr_with_en_uses_old", bus.match_pulse, 1);
    bus.en = 1; bus.in_byte = "a"; cyc();
    bus.in_byte = "b"; cyc();
    bus.en = 0;
    check("len0_disabled", bus.match_pulse, 0);
    bus.cfg_len_we = 1; bus.cfg_len = 2; cyc();
    bus.cfg_len_we = 0;
    bus.en = 1; bus.in_byte = "a"; cyc();
    bus.en = 0;
    bus.cfg_len_we = 1; bus.cfg_len = 0; cyc();
    bus.cfg_len = 2; cyc();
    bus.cfg_len_we = 0;
    bus.en = 1; bus.in_byte = "b"; cyc();
    bus.en = 0;
    check("shrink_clears_state", bus.match_pulse, 0);
    mlen = 2; manchor = 0;
    sod_only();

    // Async reset mid-match
    program_str("?open=", 1'b0);
    send_str("?open=?", 1'b1);
    rst = 1'b1;
    #2;
    check("rst_out",   bus.out, 0);
    check("rst_pulse", bus.match_pulse, 0);
    check("rst_cnt",   bus.match_cnt, 0);
    check("rst_off",   bus.match_off, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mchar[i] = 0; mnc[i] = 0; mneg[i] = 0; mloop[i] = 0;
    end
    mlen = 0; manchor = 0;
    model_clear();
    cyc();
    send_str("?open=");
    check("rst_disabled", bus.out, 0);

    // Randomized configurations and packets
    for (int p = 0; p < 60; p++) begin
      for (int a = 0; a < 16; a++) begin
        write_pos(a, ($urandom_range(0, 9) == 0) ? 8'($urandom) : alpha[$urandom_range(0, 5)],
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
      end
      write_len($urandom_range(0, 9) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 4),
                $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 0) sod_only();
      else model_clear();
      for (int b = 0; b < int'($urandom_range(4, 30)); b++) begin
        send(alpha[$urandom_range(0, 5)], (b == 0) && !(hist.size() == 0 && mcnt == 0 && bus.out == 0) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 7) == 0) idle(1);
      end
      sod_only();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
